// File: rtl/apb_mdio_controller_if.sv
// APB bus bundle shared by the MDIO management host and its requester.
// Ports: pclk, preset_n; modports completer (slave side) and requester.
interface apb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input logic pclk,
    input logic preset_n
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport completer (
        input  pclk, preset_n, psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

    modport requester (
        input  pclk, preset_n, prdata, pready, pslverr,
        output psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_mdio_controller.sv
// APB-controlled IEEE 802.3 Clause 22 MDIO host: one PHY read/write per CMD.
// Ports: apb (completer, 32b data / 10b addr, zero wait), mdc, mdio_out,
//        mdio_tris (1 = released), mdio_in (pre-synchronised pin state).
// Macro APB_MDIO_PREAMBLE_SUPPRESS_EN enables the CMD[11] NOPRE bit.
module apb_mdio_controller #(
    parameter int CLK_DIV = 50
) (
    apb_if.completer apb,
    output logic     mdc,
    output logic     mdio_out,
    output logic     mdio_tris,
    input  logic     mdio_in
);
    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_HDR, S_TA, S_DATA
    } state_t;

    localparam int DW = $clog2(2 * CLK_DIV);
    localparam logic [DW-1:0] HALF = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] FULL = DW'(2 * CLK_DIV - 1);

`ifdef APB_MDIO_PREAMBLE_SUPPRESS_EN
    localparam logic [31:0] CMD_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] CMD_MASK = 32'hFFFF_F7FF;
`endif

    state_t        state;
    state_t        nxt_state;
    logic [5:0]    bit_cnt;
    logic [5:0]    nxt_cnt;
    logic [DW-1:0] div;
    logic          busy;
    logic [31:0]   cmd_q;
    logic [15:0]   rdata;
    logic [15:0]   shreg;
    logic          last;
    logic          nxt_tris;
    logic          nxt_out;

    logic          access;
    logic          addr_cmd;
    logic          addr_sts;
    logic          cmd_wr;
    logic          start;
    logic [31:0]   cmd_new;
    logic [13:0]   hdr;
    logic [15:0]   wdata;
    logic          wr;

    assign access   = apb.psel & apb.penable;
    assign addr_cmd = (apb.paddr == 10'h000);
    assign addr_sts = (apb.paddr == 10'h004);
    assign cmd_wr   = access & apb.pwrite & addr_cmd;
    assign start    = cmd_wr & ~busy;
    assign cmd_new  = apb.pwdata & CMD_MASK;

    assign apb.pready  = access;
    assign apb.pslverr = access & (~(addr_cmd | addr_sts) | (cmd_wr & busy));
    assign apb.prdata  = !access ? 32'h0 :
                         addr_cmd ? cmd_q :
                         addr_sts ? {rdata, 15'h0, busy} : 32'h0;

    assign wr    = cmd_q[10];
    assign wdata = cmd_q[31:16];
    assign hdr   = {2'b01, wr ? 2'b01 : 2'b10, cmd_q[9:5], cmd_q[4:0]};

    // Where the frame goes after the current bit period ends.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = bit_cnt + 6'd1;
        last      = 1'b0;
        unique case (state)
            S_PRE: if (bit_cnt == 6'd31) begin
                nxt_state = S_HDR;
                nxt_cnt   = 6'd0;
            end
            S_HDR: if (bit_cnt == 6'd13) begin
                nxt_state = S_TA;
                nxt_cnt   = 6'd0;
            end
            S_TA: if (bit_cnt == 6'd1) begin
                nxt_state = S_DATA;
                nxt_cnt   = 6'd0;
            end
            S_DATA: if (bit_cnt == 6'd15) begin
                nxt_state = S_IDLE;
                nxt_cnt   = 6'd0;
                last      = 1'b1;
            end
            default: nxt_cnt = 6'd0;
        endcase
    end

    // Pin value for the next bit; reads release the line from TA onward.
    always_comb begin
        nxt_tris = 1'b1;
        nxt_out  = 1'b1;
        unique case (nxt_state)
            S_PRE: nxt_tris = 1'b0;
            S_HDR: begin
                nxt_tris = 1'b0;
                nxt_out  = hdr[4'd13 - nxt_cnt[3:0]];
            end
            S_TA: begin
                nxt_tris = ~wr;
                nxt_out  = wr ? ~nxt_cnt[0] : 1'b1;
            end
            S_DATA: begin
                nxt_tris = ~wr;
                nxt_out  = wr ? wdata[4'd15 - nxt_cnt[3:0]] : 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge apb.pclk or negedge apb.preset_n) begin
        if (!apb.preset_n) begin
            state     <= S_IDLE;
            bit_cnt   <= 6'd0;
            div       <= '0;
            busy      <= 1'b0;
            cmd_q     <= 32'h0;
            rdata     <= 16'h0;
            shreg     <= 16'h0;
            mdc       <= 1'b0;
            mdio_out  <= 1'b1;
            mdio_tris <= 1'b1;
        end else if (state == S_IDLE) begin
            if (start) begin
                cmd_q     <= cmd_new;
                busy      <= 1'b1;
                state     <= cmd_new[11] ? S_HDR : S_PRE;
                bit_cnt   <= 6'd0;
                div       <= '0;
                mdc       <= 1'b0;
                mdio_tris <= 1'b0;
                // ST begins with 0; the preamble with 1.
                mdio_out  <= ~cmd_new[11];
            end
        end else begin
            if (div == HALF) begin
                mdc <= 1'b1;
                if (state == S_DATA)
                    shreg <= {shreg[14:0], mdio_in};
            end
            if (div == FULL) begin
                div       <= '0;
                mdc       <= 1'b0;
                state     <= nxt_state;
                bit_cnt   <= nxt_cnt;
                mdio_tris <= nxt_tris;
                mdio_out  <= nxt_out;
                if (last) begin
                    busy <= 1'b0;
                    if (!wr)
                        rdata <= shreg;
                end
            end else begin
                div <= div + 1'b1;
            end
        end
    end
endmodule
